// File: rtl/f32div_seq.sv
// f32div_seq: iterative binary32 divider, one restoring quotient bit per clock.
// Subnormal inputs are prenormalized, the quotient is truncated, and tiny results flush to zero.
module f32div_seq (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out
);

    typedef enum logic [2:0] {StIdle, StPre, StDiv, StPack, StDone} state_e;

    localparam logic [31:0] QNaN = 32'h7FC00000;

    state_e             r_state;
    logic               r_sign;
    logic               r_special;
    logic [31:0]        r_spec_res;
    logic [23:0]        r_ma;
    logic [23:0]        r_mb;
    logic signed [9:0]  r_ea;
    logic signed [9:0]  r_eb;
    logic signed [9:0]  r_e;
    logic [25:0]        r_rem;
    logic [23:0]        r_div;
    logic [25:0]        r_q;
    logic [4:0]         r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [31:0]        r_out;

    logic [7:0]         w_a_exp;
    logic [7:0]         w_b_exp;
    logic               w_a_nan, w_a_inf, w_a_zero;
    logic               w_b_nan, w_b_inf, w_b_zero;
    logic               w_sign;
    logic               w_special;
    logic [31:0]        w_special_res;
    logic [4:0]         w_lz_a;
    logic [4:0]         w_lz_b;
    logic [23:0]        w_ma_norm;
    logic [23:0]        w_mb_norm;
    logic signed [9:0]  w_e_pre;
    logic               w_ge;
    logic [25:0]        w_rem_sub;
    logic [25:0]        w_rem_next;
    logic signed [9:0]  w_e_pack;
    logic [22:0]        w_frac;
    logic [31:0]        w_pack_res;

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out       = r_out;

    // Classify the incoming operands and pick the special-case result by priority.
    always_comb begin
        w_a_exp  = i_a[30:23];
        w_b_exp  = i_b[30:23];
        w_a_nan  = (w_a_exp == 8'hFF) && (i_a[22:0] != 23'd0);
        w_b_nan  = (w_b_exp == 8'hFF) && (i_b[22:0] != 23'd0);
        w_a_inf  = (w_a_exp == 8'hFF) && (i_a[22:0] == 23'd0);
        w_b_inf  = (w_b_exp == 8'hFF) && (i_b[22:0] == 23'd0);
        w_a_zero = (w_a_exp == 8'h00) && (i_a[22:0] == 23'd0);
        w_b_zero = (w_b_exp == 8'h00) && (i_b[22:0] == 23'd0);
        w_sign   = i_a[31] ^ i_b[31];
        w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_special_res = QNaN;
        end else if (w_a_inf || w_b_zero) begin
            w_special_res = {w_sign, 8'hFF, 23'd0};
        end else begin
            w_special_res = {w_sign, 31'd0};
        end
    end

    // Leading-zero counts; ascending scan so the highest set bit wins.
    always_comb begin
        w_lz_a = 5'd0;
        w_lz_b = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (r_ma[i]) w_lz_a = 5'(23 - i);
            if (r_mb[i]) w_lz_b = 5'(23 - i);
        end
        w_ma_norm = r_ma << w_lz_a;
        w_mb_norm = r_mb << w_lz_b;
        w_e_pre   = r_ea - $signed({5'd0, w_lz_a}) - r_eb + $signed({5'd0, w_lz_b})
                    + 10'sd127;
    end

    // One restoring division step.
    always_comb begin
        w_ge       = (r_rem >= {2'b00, r_div});
        w_rem_sub  = r_rem - {2'b00, r_div};
        w_rem_next = w_ge ? (w_rem_sub << 1) : (r_rem << 1);
    end

    // Normalize the quotient, truncate, and saturate the exponent range.
    always_comb begin
        if (r_q[25]) begin
            w_frac   = r_q[24:2];
            w_e_pack = r_e;
        end else begin
            w_frac   = r_q[23:1];
            w_e_pack = r_e - 10'sd1;
        end
        if (w_e_pack >= 10'sd255) begin
            w_pack_res = {r_sign, 8'hFF, 23'd0};
        end else if (w_e_pack <= 10'sd0) begin
            w_pack_res = {r_sign, 31'd0};
        end else begin
            w_pack_res = {r_sign, w_e_pack[7:0], w_frac};
        end
    end

    // Control FSM and datapath registers; handshake outputs are registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_sign      <= 1'b0;
            r_special   <= 1'b0;
            r_spec_res  <= 32'd0;
            r_ma        <= 24'd0;
            r_mb        <= 24'd0;
            r_ea        <= 10'sd0;
            r_eb        <= 10'sd0;
            r_e         <= 10'sd0;
            r_rem       <= 26'd0;
            r_div       <= 24'd0;
            r_q         <= 26'd0;
            r_cnt       <= 5'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= 32'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_sign     <= w_sign;
                        r_special  <= w_special;
                        r_spec_res <= w_special_res;
                        // Field exponent 0 means exponent 1 with no hidden bit.
                        r_ma <= {(w_a_exp != 8'd0), i_a[22:0]};
                        r_mb <= {(w_b_exp != 8'd0), i_b[22:0]};
                        r_ea <= $signed({2'b00, (w_a_exp == 8'd0) ? 8'd1 : w_a_exp});
                        r_eb <= $signed({2'b00, (w_b_exp == 8'd0) ? 8'd1 : w_b_exp});
                        r_state <= StPre;
                    end
                end
                StPre: begin
                    // Specials resolve here, one cycle after acceptance.
                    if (r_special) begin
                        r_out       <= r_spec_res;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end else begin
                        r_e     <= w_e_pre;
                        r_rem   <= {2'b00, w_ma_norm};
                        r_div   <= w_mb_norm;
                        r_q     <= 26'd0;
                        r_cnt   <= 5'd0;
                        r_state <= StDiv;
                    end
                end
                StDiv: begin
                    r_q   <= {r_q[24:0], w_ge};
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd25) r_state <= StPack;
                end
                StPack: begin
                    r_out       <= w_pack_res;
                    r_out_valid <= 1'b1;
                    r_state     <= StDone;
                end
                StDone: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
